// File: rtl/mem_write_arbiter.sv
// Round-robin arbiter sharing the memory write port between A (CPU stores) and B (loader/debug).
// Accept-to-done is 2+N cycles (N = memory wait); requesters hold valid until ready, one write in flight.
module mem_write_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        a_valid,
    output logic        a_ready,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_data,
    input  logic [2:0]  a_bytes,
    output logic        a_done,
    output logic        a_err,

    input  logic        b_valid,
    output logic        b_ready,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_data,
    input  logic [2:0]  b_bytes,
    output logic        b_done,
    output logic        b_err,

    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    output logic [2:0]  mem_bytes_to_write,
    output logic        mem_write_data_valid,
    input  logic        mem_write_done,

    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic          last_b_q;
    logic          gnt_b_q;
    logic [31:0]   addr_q;
    logic [31:0]   data_q;
    logic [2:0]    bytes_q;
    logic [CW-1:0] cnt_q;
    logic          a_done_q;
    logic          a_err_q;
    logic          b_done_q;
    logic          b_err_q;

    logic          in_idle;
    logic          gnt_b_d;
    logic [2:0]    bytes_d;
    logic          size_ok_d;

    // Ready is gated by rst_n so no accept is advertised while reset is held.
    assign in_idle   = rst_n && (state_q == S_IDLE);
    assign gnt_b_d   = b_valid && (!a_valid || !last_b_q);
    assign a_ready   = in_idle && a_valid && !gnt_b_d;
    assign b_ready   = in_idle && gnt_b_d;
    assign bytes_d   = gnt_b_d ? b_bytes : a_bytes;
    assign size_ok_d = (bytes_d == 3'd1) || (bytes_d == 3'd2) || (bytes_d == 3'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            last_b_q <= 1'b1;
            gnt_b_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            bytes_q  <= '0;
            cnt_q    <= '0;
            a_done_q <= 1'b0;
            a_err_q  <= 1'b0;
            b_done_q <= 1'b0;
            b_err_q  <= 1'b0;
        end else begin
            a_done_q <= 1'b0;
            a_err_q  <= 1'b0;
            b_done_q <= 1'b0;
            b_err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (a_valid || b_valid) begin
                        gnt_b_q  <= gnt_b_d;
                        last_b_q <= gnt_b_d;
                        addr_q   <= gnt_b_d ? b_addr : a_addr;
                        data_q   <= gnt_b_d ? b_data : a_data;
                        bytes_q  <= bytes_d;
                        cnt_q    <= '0;
                        if (size_ok_d) begin
                            state_q <= S_BUSY;
                        end else begin
                            // Illegal size: answer with an error without touching memory.
                            state_q  <= S_DONE;
                            a_done_q <= !gnt_b_d;
                            a_err_q  <= !gnt_b_d;
                            b_done_q <= gnt_b_d;
                            b_err_q  <= gnt_b_d;
                        end
                    end
                end
                S_BUSY: begin
                    if (mem_write_done || (cnt_q == CNT_LAST)) begin
                        state_q  <= S_DONE;
                        a_done_q <= !gnt_b_q;
                        a_err_q  <= !gnt_b_q && !mem_write_done;
                        b_done_q <= gnt_b_q;
                        b_err_q  <= gnt_b_q && !mem_write_done;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign a_done               = a_done_q;
    assign a_err                = a_err_q;
    assign b_done               = b_done_q;
    assign b_err                = b_err_q;
    assign mem_write_addr       = addr_q;
    assign mem_write_data       = data_q;
    assign mem_write_data_valid = (state_q == S_BUSY);
    assign mem_bytes_to_write   = (state_q == S_BUSY) ? bytes_q : 3'd0;
    assign busy                 = (state_q != S_IDLE);

endmodule
